// File: rtl/jtcontra_dwnld_ctl.sv
// jtcontra_dwnld_ctl: ioctl byte stream to SDRAM/PROM programming writes through a 4-entry FIFO.
// Optional JTCONTRA_DWNLD_CHECKSUM_EN adds a 16-bit running byte checksum output.
module jtcontra_dwnld_ctl #(
    parameter logic [24:0] PROM_START = 25'h128_000,
    parameter int          PROM_AW    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic        prom_we,
    input  logic        sdram_ack,
`ifdef JTCONTRA_DWNLD_CHECKSUM_EN
    output logic [15:0] checksum,
`endif
    output logic        busy,
    output logic        overflow
);
    localparam logic [24:0] PROM_END = PROM_START + (25'd1 << PROM_AW);

    typedef enum logic [1:0] {IDLE, REQ, PROM, GAP} state_t;
    typedef struct packed {
        logic        prom;
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [7:0]  data;
    } entry_t;

    state_t      state, state_nx;
    entry_t      fifo [4];
    entry_t      head, new_entry;
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic [24:0] prom_off;
    logic        dl_q, dl_rise, accept, push, pop, drop, load;

    assign prom_off  = ioctl_addr - PROM_START;
    assign new_entry = ioctl_addr >= PROM_START
                     ? {1'b1, 22'(prom_off[PROM_AW-1:0]), 2'b11, ioctl_dout}
                     : {1'b0, ioctl_addr[22:1], ioctl_addr[0] ? 2'b01 : 2'b10, ioctl_dout};
    assign head      = fifo[rd_ptr];
    assign accept    = downloading & ioctl_wr & (ioctl_addr < PROM_END);
    assign push      = accept & (~count[2] | pop);
    assign drop      = accept & count[2] & ~pop;
    assign dl_rise   = downloading & ~dl_q;
    assign busy      = downloading | (count != 3'd0) | (state != IDLE);

    always_comb begin
        state_nx = state == IDLE ? (count == 3'd0 ? IDLE : head.prom ? PROM : REQ)
                 : state == REQ  ? (sdram_ack ? GAP : REQ)
                 : state == PROM ? GAP
                 : IDLE;
        load     = state == IDLE && count != 3'd0;
        pop      = (state == REQ && sdram_ack) || state == PROM;
        prog_we  = state == REQ;
        prom_we  = state == PROM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dl_q      <= 1'b0;
            overflow  <= 1'b0;
            prog_addr <= '0;
            prog_mask <= '0;
            prog_data <= '0;
        end else begin
            state    <= state_nx;
            wr_ptr   <= wr_ptr + 2'(push);
            rd_ptr   <= rd_ptr + 2'(pop);
            count    <= count + 3'(push) - 3'(pop);
            dl_q     <= downloading;
            overflow <= dl_rise ? 1'b0 : overflow | drop;
            if (load) {prog_addr, prog_mask, prog_data} <= {head.addr, head.mask, head.data};
        end
    end

    // Payload storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= new_entry;
    end

`ifdef JTCONTRA_DWNLD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) checksum <= '0;
        else if (dl_rise) checksum <= '0;
        else if (push) checksum <= checksum + 16'(ioctl_dout);
    end
`endif
endmodule

// File: tb/tb_jtcontra_dwnld_ctl.sv
// tb_jtcontra_dwnld_ctl: scoreboard bench for the download controller.
module tb_jtcontra_dwnld_ctl;
    typedef struct packed {
        logic        prom;
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 0, rst_n = 0, downloading = 0, ioctl_wr = 0, sdram_ack = 0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we, prom_we, busy, overflow;
`ifdef JTCONTRA_DWNLD_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    exp_t sb[$];
    exp_t cur;
    int   checks = 0, failures = 0, we_rises = 0, prom_pulses = 0, we_len = 0, last_len = 0;
    logic mon_we_q = 0, mon_prom_q = 0;
    bit   ack_hold = 0;

    jtcontra_dwnld_ctl dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prom_we(prom_we), .sdram_ack(sdram_ack),
`ifdef JTCONTRA_DWNLD_CHECKSUM_EN
        .checksum(checksum),
`endif
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [24:0] a, input logic [7:0] d);
        logic [24:0] off;
        off = a - 25'h128_000;
        return a >= 25'h128_000 ? {1'b1, off[21:0], 2'b11, d}
                                : {1'b0, a[22:1], a[0] ? 2'b01 : 2'b10, d};
    endfunction

    // Output monitor and SDRAM acknowledge model: ack arrives in the second cycle of a request.
    always @(negedge clk) begin
        checks++;
        if ((prog_we & prom_we) !== 1'b0) begin
            failures++;
            $display("FAIL both_we prog_we=%b prom_we=%b required not both", prog_we, prom_we);
        end
        if (prog_we && !mon_we_q) begin
            we_rises++;
            we_len = 1;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_sdram addr=%h data=%h required none", prog_addr, prog_data);
            end else begin
                cur = sb.pop_front();
                if ({1'b0, prog_addr, prog_mask, prog_data} !== cur) begin
                    failures++;
                    $display("FAIL sdram_entry got=%h required=%h", {1'b0, prog_addr, prog_mask, prog_data}, cur);
                end
            end
        end else if (prog_we) begin
            we_len++;
            checks++;
            if ({prog_addr, prog_mask, prog_data} !== {cur.addr, cur.mask, cur.data}) begin
                failures++;
                $display("FAIL stable got=%h required=%h", {prog_addr, prog_mask, prog_data}, {cur.addr, cur.mask, cur.data});
            end
        end
        if (!prog_we && mon_we_q) last_len = we_len;
        if (prom_we) begin
            prom_pulses++;
            checks++;
            if (mon_prom_q !== 1'b0) begin
                failures++;
                $display("FAIL prom_pulse_len got=multi required=1");
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_prom addr=%h required none", prog_addr);
            end else begin
                cur = sb.pop_front();
                if ({1'b1, prog_addr, prog_mask, prog_data} !== cur) begin
                    failures++;
                    $display("FAIL prom_entry got=%h required=%h", {1'b1, prog_addr, prog_mask, prog_data}, cur);
                end
            end
        end
        sdram_ack = prog_we && mon_we_q && !ack_hold;
        mon_we_q = prog_we;
        mon_prom_q = prom_we;
    end

    task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit exp);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1;
        if (exp) sb.push_back(model(a, d));
        @(negedge clk);
        ioctl_wr = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({prog_addr, prog_data, prog_mask, prog_we, prom_we, overflow, busy} !== '0) begin
            failures++;
            $display("FAIL reset outs=%h required=0", {prog_addr, prog_data, prog_mask, prog_we, prom_we, overflow, busy});
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_sdram();
        int r0;
        downloading = 1;
        @(negedge clk);
        r0 = we_rises;
        wr(25'h000_0003, 8'hA5, 1);
        checks++;
        if (prog_we !== 1'b0) begin failures++; $display("FAIL latency_c1 prog_we=%b required=0", prog_we); end
        @(negedge clk);
        checks++;
        if (prog_we !== 1'b1) begin failures++; $display("FAIL latency_c2 prog_we=%b required=1", prog_we); end
        drain();
        checks++;
        if (last_len !== 2 || we_rises - r0 !== 1) begin
            failures++;
            $display("FAIL sdram_len len=%0d rises=%0d required 2 and 1", last_len, we_rises - r0);
        end
        downloading = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL sdram_busy busy=%b required=0", busy); end
    endtask

    task automatic test_prom();
        int r0, p0;
        downloading = 1;
        @(negedge clk);
        r0 = we_rises;
        p0 = prom_pulses;
        wr(25'h128_005, 8'h0C, 1);
        drain();
        checks++;
        if (we_rises != r0 || prom_pulses - p0 != 1) begin
            failures++;
            $display("FAIL prom_basic rises=%0d pulses=%0d required 0 and 1", we_rises - r0, prom_pulses - p0);
        end
        wr(25'h128_3FF, 8'h77, 1);
        wr(25'h127_FFF, 8'h11, 1);
        wr(25'h128_000, 8'h22, 1);
        drain();
        checks++;
        if (we_rises - r0 != 1 || prom_pulses - p0 != 3) begin
            failures++;
            $display("FAIL prom_bounds rises=%0d pulses=%0d required 1 and 3", we_rises - r0, prom_pulses - p0);
        end
    endtask

    task automatic test_discard();
        int r0, p0;
        r0 = we_rises;
        p0 = prom_pulses;
        wr(25'h128_400, 8'h5A, 0);
        wr(25'h1FF_FFFF, 8'h33, 0);
        downloading = 0;
        @(negedge clk);
        wr(25'h000_0010, 8'h44, 0);
        repeat (6) @(negedge clk);
        checks++;
        if (we_rises != r0 || prom_pulses != p0) begin
            failures++;
            $display("FAIL discard rises=%0d pulses=%0d required 0 and 0", we_rises - r0, prom_pulses - p0);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL discard_busy busy=%b required=0", busy); end
    endtask

    task automatic test_overflow();
        int r0;
        downloading = 1;
        ack_hold = 1;
        @(negedge clk);
        r0 = we_rises;
        for (int i = 0; i < 5; i++) wr(25'h000_0100 + 25'(i), 8'h10 + 8'(i), i < 4);
        checks++;
        if (overflow !== 1'b1 || prog_we !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set overflow=%b prog_we=%b required 1 and 1", overflow, prog_we);
        end
        ack_hold = 0;
        drain();
        checks++;
        if (we_rises - r0 != 4 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_drain rises=%0d overflow=%b required 4 and 1", we_rises - r0, overflow);
        end
        downloading = 0;
        @(negedge clk);
        downloading = 1;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear overflow=%b required=0", overflow); end
    endtask

    task automatic test_back_to_back();
        int r0, p0;
        r0 = we_rises;
        p0 = prom_pulses;
        wr(25'h000_0200, 8'h01, 1);
        wr(25'h128_010, 8'h02, 1);
        wr(25'h000_0201, 8'h03, 1);
        wr(25'h128_011, 8'h04, 1);
        downloading = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_drain busy=%b required=1", busy); end
        drain();
        checks++;
        if (busy !== 1'b0 || we_rises - r0 != 2 || prom_pulses - p0 != 2) begin
            failures++;
            $display("FAIL b2b_done busy=%b rises=%0d pulses=%0d required 0 2 2", busy, we_rises - r0, prom_pulses - p0);
        end
    endtask

    task automatic test_reset_mid();
        int r0, p0;
        downloading = 1;
        ack_hold = 1;
        @(negedge clk);
        wr(25'h000_0300, 8'hB1, 1);
        wr(25'h000_0302, 8'hB2, 1);
        wr(25'h000_0304, 8'hB3, 1);
        #2 rst_n = 0;
        #1;
        checks++;
        if (prog_we !== 1'b0 || prom_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_async prog_we=%b prom_we=%b required 0 0", prog_we, prom_we);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        ack_hold = 0;
        r0 = we_rises;
        p0 = prom_pulses;
        repeat (10) @(negedge clk);
        checks++;
        if (we_rises != r0 || prom_pulses != p0 || busy !== downloading) begin
            failures++;
            $display("FAIL reset_mid rises=%0d pulses=%0d busy=%b required 0 0 %b", we_rises - r0, prom_pulses - p0, busy, downloading);
        end
        downloading = 0;
        @(negedge clk);
    endtask

`ifdef JTCONTRA_DWNLD_CHECKSUM_EN
    task automatic test_checksum();
        logic [15:0] sum;
        downloading = 1;
        @(negedge clk);
        checks++;
        if (checksum !== 16'h0) begin failures++; $display("FAIL csum_clear got=%h required=0000", checksum); end
        wr(25'h000_0400, 8'hFF, 1);
        wr(25'h128_020, 8'h02, 1);
        drain();
        checks++;
        if (checksum !== 16'h0101) begin failures++; $display("FAIL csum_pair got=%h required=0101", checksum); end
        downloading = 0;
        @(negedge clk);
        downloading = 1;
        @(negedge clk);
        sum = 0;
        for (int i = 0; i < 258; i++) begin
            wr(25'h000_1000 + 25'(i), 8'hFF, 1);
            sum = sum + 16'hFF;
            repeat (5) @(negedge clk);
            if (i == 256) begin
                checks++;
                if (checksum !== 16'hFFFF || checksum !== sum) begin
                    failures++;
                    $display("FAIL csum_257 got=%h required=FFFF", checksum);
                end
            end
        end
        drain();
        checks++;
        if (checksum !== sum || overflow !== 1'b0) begin
            failures++;
            $display("FAIL csum_wrap got=%h overflow=%b required=%h 0", checksum, overflow, sum);
        end
        downloading = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_sdram();
        test_prom();
        test_discard();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef JTCONTRA_DWNLD_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
